serial_word_tx: RTL and testbench
=================================

SERIAL_WORD_TX -- requirements
Module: serial_word_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the number of bits per word.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 Port din, input, WIDTH bits: parallel word to serialize.
REQ-005 Port din_valid, input, 1 bit: din holds a word to be accepted.
REQ-006 Port din_ready, output, 1 bit: the block can accept a word this cycle.
REQ-007 Port sout, output, 1 bit: serial data, MSB first; feeds the sin input of the downstream left-shift register.
REQ-008 Port sout_valid, output, 1 bit: sout carries a data bit this cycle.
REQ-009 Port word_done, output, 1 bit: one-cycle pulse while the last bit (LSB) of a word is on sout.
REQ-010 Port busy, output, 1 bit: the shifter or the holding register holds an unsent word.

Function
REQ-011 A word SHALL be accepted on a rising edge where reset=1, din_valid=1 and din_ready=1; din is then captured into a one-entry holding register.
REQ-012 din_ready SHALL equal (reset=1) AND (holding register empty); it SHALL have no combinational path from din_valid.
REQ-013 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-014 IDLE -> SHIFT: on an edge where the holding register is full, the shifter loads that word, sout=din[WIDTH-1] and sout_valid=1 after the edge, and the holding register empties.
REQ-015 In SHIFT, the shifter SHALL shift left by one bit per edge; sout shows bits WIDTH-1 down to 0 on consecutive cycles.
REQ-016 A WIDTH-bit down-counter SHALL track the bit index; word_done SHALL be 1 exactly in the cycle where bit 0 is on sout.
REQ-017 On the edge ending the word_done cycle, the FSM SHALL load the next word if the holding register is full (stays in SHIFT, no gap); otherwise it goes to IDLE with sout=0 and sout_valid=0.
REQ-018 Latency from acceptance edge k: first bit on sout after edge k+1 when IDLE; word_done after edge k+WIDTH.
REQ-019 Continuous streaming SHALL sustain one word per WIDTH cycles with no idle bit between words.
REQ-020 While the holding register is full and not being unloaded, din_valid SHALL be ignored and no word dropped or overwritten.
REQ-021 Loading the holding register and unloading it into the shifter on the same edge SHALL NOT occur, because din_ready is low while the register is full.
REQ-022 busy SHALL be 1 when the FSM is in SHIFT or the holding register is full, and 0 otherwise.
REQ-023 In IDLE, sout SHALL be 0 and sout_valid, word_done and busy SHALL be 0.

Reset
REQ-024 On any edge with reset=0: FSM=IDLE, holding register empty, shifter=0, counter=0.
REQ-025 After that edge, sout=0, sout_valid=0, word_done=0 and busy=0.
REQ-026 din_ready SHALL be 0 while reset=0 and 1 in the first cycle after release.
REQ-027 Reset asserted mid-word SHALL discard the word in flight and the held word; no further bits of either SHALL appear.
REQ-028 No word SHALL be accepted on an edge where reset=0.

Verification
REQ-029 Single word (WIDTH=4): accept 4'b1011 at edge k.
- sout=1,0,1,1 after edges k+1..k+4, with sout_valid=1 throughout.
- word_done=1 only after edge k+4.
- A downstream 4-bit left-shift register then reads 1011.
REQ-030 Back-to-back words: hold din_valid=1 with 1011 then 0110.
- sout=1,0,1,1,0,1,1,0 on 8 consecutive cycles with no gap.
- word_done pulses twice, 4 cycles apart.
REQ-031 Backpressure: present 1100 while the holding register is full.
- din_ready=0 until the held word moves into the shifter.
- 1100 is accepted afterwards and serialized intact.
REQ-032 Reset mid-word: assert reset=0 after bit 2 of 1011 has been sent.
- After the next edge: sout=0, sout_valid=0, busy=0.
- After release, 0101 serializes as 0,1,0,1.
REQ-033 Idle after completion: one word with din_valid=0 afterwards.
- After the last bit: sout=0, sout_valid=0, busy=0, din_ready=1, held indefinitely.

Source files
------------

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter: one-entry holding register feeding an
// MSB-first left shifter, with a per-word completion pulse.
`timescale 1ns/1ps
module serial_word_tx #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             word_done,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(WIDTH - 1);

  state_e           state_q, state_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;

  logic accept;
  logic last_bit;
  logic load;

  // din_ready depends only on reset and registered state, never on din_valid.
  assign din_ready = reset & ~hold_full_q;
  assign accept    = din_valid & din_ready;
  assign last_bit  = (state_q == SHIFT) && (cnt_q == '0);
  assign load      = hold_full_q & ((state_q == IDLE) | last_bit);

  assign sout       = (state_q == SHIFT) ? shift_q[WIDTH-1] : 1'b0;
  assign sout_valid = (state_q == SHIFT);
  assign word_done  = last_bit;
  assign busy       = (state_q == SHIFT) | hold_full_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      shift_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          state_d = SHIFT;
          shift_d = hold_q;
          cnt_d   = LAST_IDX;
        end
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          // Chain straight into the held word so streaming has no idle bit.
          if (hold_full_q) begin
            shift_d = hold_q;
            cnt_d   = LAST_IDX;
          end else begin
            state_d = IDLE;
            shift_d = '0;
          end
        end else begin
          shift_d = shift_q << 1;
          cnt_d   = cnt_q - WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        shift_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // accept implies the register was empty, so load and accept never coincide.
  always_comb begin
    hold_full_d = hold_full_q;
    hold_d      = hold_q;
    if (load) begin
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_full_d = 1'b1;
      hold_d      = din;
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed self-checking bench for serial_word_tx (WIDTH=4) with a downstream
// 4-bit left-shift receiver model.
`timescale 1ns/1ps
module tb_serial_word_tx;

  localparam int unsigned W = 4;

  logic         clk;
  logic         reset;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         sout;
  logic         sout_valid;
  logic         word_done;
  logic         busy;

  logic [W-1:0] rx;
  int           checks;
  int           errors;

  serial_word_tx #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .word_done  (word_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream left-shift register fed from sout.
  always @(posedge clk) begin
    if (sout_valid) rx <= {rx[W-2:0], sout};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observed vector order: {sout, sout_valid, word_done, busy, din_ready}
  task automatic test_reset();
    logic [4:0] obs;
    reset = 1'b0; din = 4'hF; din_valid = 1'b1;
    tick(); tick();
    obs = {sout, sout_valid, word_done, busy, din_ready};
    checks++;
    if (obs !== 5'b00000) begin
      errors++;
      $display("FAIL reset_state: got %b expected %b", obs, 5'b00000);
    end
    din_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release: got %b expected 1", din_ready);
    end
    tick();
    obs = {sout, sout_valid, word_done, busy, din_ready};
    checks++;
    if (obs !== 5'b00001) begin
      errors++;
      $display("FAIL no_accept_in_reset: got %b expected %b", obs, 5'b00001);
    end
  endtask

  task automatic test_single();
    logic [W-1:0] word;
    logic [4:0]   obs, exp;
    word = 4'b1011;
    din = word; din_valid = 1'b1;
    #1;
    checks++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready_pre: got %b expected 1", din_ready);
    end
    tick();
    din_valid = 1'b0;
    obs = {sout, sout_valid, word_done, busy, din_ready};
    checks++;
    if (obs !== 5'b00010) begin
      errors++;
      $display("FAIL single_held: got %b expected %b", obs, 5'b00010);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = {word[3-i], 1'b1, (i == 3), 1'b1, 1'b1};
      obs = {sout, sout_valid, word_done, busy, din_ready};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL single_bit%0d: got %b expected %b", i, obs, exp);
      end
    end
    tick();
    obs = {sout, sout_valid, word_done, busy, din_ready};
    checks++;
    if (obs !== 5'b00001) begin
      errors++;
      $display("FAIL single_end: got %b expected %b", obs, 5'b00001);
    end
    checks++;
    if (rx !== 4'b1011) begin
      errors++;
      $display("FAIL single_rx: got %b expected %b", rx, 4'b1011);
    end
  endtask

  task automatic test_idle();
    logic [4:0] obs;
    for (int i = 0; i < 6; i++) begin
      tick();
      obs = {sout, sout_valid, word_done, busy, din_ready};
      checks++;
      if (obs !== 5'b00001) begin
        errors++;
        $display("FAIL idle_cycle%0d: got %b expected %b", i, obs, 5'b00001);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] stream;
    logic [4:0] obs, exp;
    logic       rdy;
    stream = 8'b1011_0110;
    din = 4'b1011; din_valid = 1'b1;
    tick();
    din = 4'b0110;
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (j == 2) din_valid = 1'b0;
      rdy = (j == 1) || (j >= 5);
      exp = {stream[8-j], 1'b1, (j == 4 || j == 8), 1'b1, rdy};
      obs = {sout, sout_valid, word_done, busy, din_ready};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL b2b_cycle%0d: got %b expected %b", j, obs, exp);
      end
    end
    tick();
    obs = {sout, sout_valid, word_done, busy, din_ready};
    checks++;
    if (obs !== 5'b00001) begin
      errors++;
      $display("FAIL b2b_end: got %b expected %b", obs, 5'b00001);
    end
    checks++;
    if (rx !== 4'b0110) begin
      errors++;
      $display("FAIL b2b_rx: got %b expected %b", rx, 4'b0110);
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] stream, rdy_tab;
    logic [4:0]  obs, exp;
    stream  = 12'b1011_0110_1100;
    rdy_tab = 12'b1000_1000_1111;
    din = 4'b1011; din_valid = 1'b1;
    tick();
    din = 4'b0110;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (j == 2) din = 4'b1100;
      if (j == 6) din_valid = 1'b0;
      exp = {stream[12-j], 1'b1, (j == 4 || j == 8 || j == 12), 1'b1, rdy_tab[12-j]};
      obs = {sout, sout_valid, word_done, busy, din_ready};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL bp_cycle%0d: got %b expected %b", j, obs, exp);
      end
    end
    tick();
    obs = {sout, sout_valid, word_done, busy, din_ready};
    checks++;
    if (obs !== 5'b00001) begin
      errors++;
      $display("FAIL bp_end: got %b expected %b", obs, 5'b00001);
    end
    checks++;
    if (rx !== 4'b1100) begin
      errors++;
      $display("FAIL bp_rx: got %b expected %b", rx, 4'b1100);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [W-1:0] word;
    logic [4:0]   obs, exp;
    din = 4'b1011; din_valid = 1'b1;
    tick();
    din = 4'b1111;
    tick();
    tick();
    din_valid = 1'b0;
    obs = {sout, sout_valid, word_done, busy, din_ready};
    checks++;
    if (obs !== 5'b01010) begin
      errors++;
      $display("FAIL mid_bit2: got %b expected %b", obs, 5'b01010);
    end
    reset = 1'b0;
    tick();
    obs = {sout, sout_valid, word_done, busy, din_ready};
    checks++;
    if (obs !== 5'b00000) begin
      errors++;
      $display("FAIL mid_reset: got %b expected %b", obs, 5'b00000);
    end
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      obs = {sout, sout_valid, word_done, busy, din_ready};
      checks++;
      if (obs !== 5'b00001) begin
        errors++;
        $display("FAIL mid_discard%0d: got %b expected %b", i, obs, 5'b00001);
      end
    end
    word = 4'b0101;
    din = word; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = {word[3-i], 1'b1, (i == 3), 1'b1, 1'b1};
      obs = {sout, sout_valid, word_done, busy, din_ready};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL mid_after_bit%0d: got %b expected %b", i, obs, exp);
      end
    end
    tick();
    checks++;
    if (rx !== 4'b0101) begin
      errors++;
      $display("FAIL mid_after_rx: got %b expected %b", rx, 4'b0101);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rx = '0;
    reset = 1'b0;
    din = '0;
    din_valid = 1'b0;
    test_reset();
    test_single();
    test_idle();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
